// File: rtl/tetris_vga_avl_master.sv
// Avalon-MM write initiator that flushes palette, level/lines, score and dirty board rows to the VGA slave.
// Optional build macro VSYNC_ALIGN_EN holds each flush until the next registered falling edge of VS.
module tetris_vga_avl_master #(
    parameter int          NUM_ROWS   = 20,
    parameter logic [11:0] ROW0_ADDR  = 12'h002,
    parameter logic [11:0] LVL_ADDR   = 12'h000,
    parameter logic [11:0] SCORE_ADDR = 12'h001,
    parameter logic [11:0] PAL_ADDR   = 12'h800
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ROW_WE,
    input  logic [4:0]  ROW_IDX,
    input  logic [19:0] ROW_DATA,
    input  logic        GAMEOVER,
    input  logic [31:0] SCORE,
    input  logic [15:0] LEVEL,
    input  logic [15:0] LINES,
    input  logic [31:0] PALETTE,
    input  logic        VS,
    input  logic        FLUSH_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic [11:0] AVM_ADDR,
    output logic        AVM_WRITE,
    output logic        AVM_CS,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST
);

    localparam logic [2:0] IDLE    = 3'd0;
`ifdef VSYNC_ALIGN_EN
    localparam logic [2:0] WAIT_VS = 3'd1;
`endif
    localparam logic [2:0] PAL     = 3'd2;
    localparam logic [2:0] LVL     = 3'd3;
    localparam logic [2:0] SCR     = 3'd4;
    localparam logic [2:0] ROWS    = 3'd5;
    localparam logic [2:0] FIN     = 3'd6;
    localparam logic [4:0] ROW_LIM = 5'(NUM_ROWS);

    logic [2:0]          state_r;
    logic                busy_r, done_r, avm_write_r, pending_r, go_prev_r, go_snap_r;
    logic [11:0]         avm_addr_r;
    logic [31:0]         avm_data_r, score_snap_r;
    logic [15:0]         level_snap_r, lines_snap_r;
    logic [NUM_ROWS-1:0] dirty_r, work_r, dirty_next_s, masked_s;
    logic [19:0]         shadow_r [NUM_ROWS];
    logic [4:0]          cur_row_r, next_row_s;
    logic                next_any_s, accept_s, start_s, row_ok_s;
    logic [31:0]         row_word_s;

`ifdef VSYNC_ALIGN_EN
    logic        vs_r, vs_d_r;
    logic [31:0] pal_snap_r;
`else
    logic        unused_vs_s;
    assign unused_vs_s = VS;
`endif

    assign accept_s   = avm_write_r & ~AVM_WAITREQUEST;
    assign start_s    = (state_r == IDLE) & (FLUSH_REQ | pending_r);
    assign row_ok_s   = ROW_WE & (ROW_IDX < ROW_LIM);
    assign row_word_s = {11'b0, go_snap_r, shadow_r[next_row_s]};

    // Live dirty mask: a flush start clears it, but any set in the same cycle wins.
    always_comb begin
        dirty_next_s = dirty_r;
        if (start_s) begin
            dirty_next_s = '0;
        end else begin
            dirty_next_s = dirty_r;
        end
        if (GAMEOVER != go_prev_r) begin
            dirty_next_s = '1;
        end else begin
            dirty_next_s = dirty_next_s;
        end
        if (row_ok_s) begin
            dirty_next_s[ROW_IDX] = 1'b1;
        end else begin
            dirty_next_s = dirty_next_s;
        end
    end

    // Next row to send: lowest remaining work bit, skipping the row currently on the bus.
    always_comb begin
        masked_s   = work_r;
        next_row_s = 5'd0;
        next_any_s = 1'b0;
        if (state_r == ROWS) begin
            masked_s[cur_row_r] = 1'b0;
        end else begin
            masked_s = work_r;
        end
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (masked_s[i]) begin
                next_row_s = 5'(i);
                next_any_s = 1'b1;
            end else begin
                next_any_s = next_any_s;
            end
        end
    end

    // Shadow rows, dirty tracking, pending request and GAMEOVER edge register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dirty_r   <= '1;
            pending_r <= 1'b0;
            go_prev_r <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                shadow_r[i] <= 20'h00000;
            end
        end else begin
            dirty_r   <= dirty_next_s;
            go_prev_r <= GAMEOVER;
            if (row_ok_s) begin
                shadow_r[ROW_IDX] <= ROW_DATA;
            end
            if (start_s) begin
                pending_r <= 1'b0;
            end else if (FLUSH_REQ) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Flush sequencer; bus outputs are registered and held while the slave stalls.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            avm_write_r  <= 1'b0;
            avm_addr_r   <= 12'h000;
            avm_data_r   <= 32'h0000_0000;
            work_r       <= '0;
            cur_row_r    <= 5'd0;
            go_snap_r    <= 1'b0;
            score_snap_r <= 32'h0000_0000;
            level_snap_r <= 16'h0000;
            lines_snap_r <= 16'h0000;
`ifdef VSYNC_ALIGN_EN
            vs_r         <= 1'b0;
            vs_d_r       <= 1'b0;
            pal_snap_r   <= 32'h0000_0000;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef VSYNC_ALIGN_EN
            vs_r   <= VS;
            vs_d_r <= vs_r;
`endif
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        work_r       <= dirty_r;
                        busy_r       <= 1'b1;
                        go_snap_r    <= GAMEOVER;
                        score_snap_r <= SCORE;
                        level_snap_r <= LEVEL;
                        lines_snap_r <= LINES;
`ifdef VSYNC_ALIGN_EN
                        pal_snap_r   <= PALETTE;
                        state_r      <= WAIT_VS;
`else
                        avm_write_r  <= 1'b1;
                        avm_addr_r   <= PAL_ADDR;
                        avm_data_r   <= PALETTE;
                        state_r      <= PAL;
`endif
                    end
                end
`ifdef VSYNC_ALIGN_EN
                WAIT_VS: begin
                    if (vs_d_r && !vs_r) begin
                        avm_write_r <= 1'b1;
                        avm_addr_r  <= PAL_ADDR;
                        avm_data_r  <= pal_snap_r;
                        state_r     <= PAL;
                    end
                end
`endif
                PAL: begin
                    if (accept_s) begin
                        avm_addr_r <= LVL_ADDR;
                        avm_data_r <= {level_snap_r, lines_snap_r};
                        state_r    <= LVL;
                    end
                end
                LVL: begin
                    if (accept_s) begin
                        avm_addr_r <= SCORE_ADDR;
                        avm_data_r <= score_snap_r;
                        state_r    <= SCR;
                    end
                end
                SCR, ROWS: begin
                    if (accept_s) begin
                        work_r <= masked_s;
                        if (next_any_s) begin
                            cur_row_r  <= next_row_s;
                            avm_addr_r <= ROW0_ADDR + {7'b0, next_row_s};
                            avm_data_r <= row_word_s;
                            state_r    <= ROWS;
                        end else begin
                            avm_write_r <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= FIN;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    avm_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign AVM_WRITE     = avm_write_r;
    assign AVM_CS        = avm_write_r;
    assign AVM_ADDR      = avm_addr_r;
    assign AVM_WRITEDATA = avm_data_r;
    assign AVM_BYTE_EN   = 4'b1111;

endmodule

// File: tb/tb_tetris_vga_avl_master.sv
// Scoreboard bench for tetris_vga_avl_master (default build, VSYNC_ALIGN_EN undefined).
module tb_tetris_vga_avl_master;

    logic        CLK = 1'b0;
    logic        RESET, ROW_WE, GAMEOVER, VS, FLUSH_REQ, AVM_WAITREQUEST;
    logic [4:0]  ROW_IDX;
    logic [19:0] ROW_DATA;
    logic [31:0] SCORE, PALETTE;
    logic [15:0] LEVEL, LINES;
    logic        BUSY, DONE, AVM_WRITE, AVM_CS;
    logic [11:0] AVM_ADDR;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;

    tetris_vga_avl_master dut (
        .CLK(CLK), .RESET(RESET), .ROW_WE(ROW_WE), .ROW_IDX(ROW_IDX), .ROW_DATA(ROW_DATA),
        .GAMEOVER(GAMEOVER), .SCORE(SCORE), .LEVEL(LEVEL), .LINES(LINES), .PALETTE(PALETTE),
        .VS(VS), .FLUSH_REQ(FLUSH_REQ), .BUSY(BUSY), .DONE(DONE), .AVM_ADDR(AVM_ADDR),
        .AVM_WRITE(AVM_WRITE), .AVM_CS(AVM_CS), .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0, n_fail = 0, cyc = 0, busy_cnt = 0, done_cnt = 0, last_acc_cyc = -10;
    logic [43:0] exp_q [$];
    logic [19:0] shadow_m [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [11:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic push_header();
        push(12'h800, PALETTE);
        push(12'h000, {LEVEL, LINES});
        push(12'h001, SCORE);
    endtask

    task automatic push_rows(input logic go);
        for (int r = 0; r < 20; r++) begin
            push(12'h002 + 12'(r), {11'b0, go, shadow_m[r]});
        end
    endtask

    task automatic row_write(input logic [4:0] idx, input logic [19:0] data);
        @(posedge CLK); #1;
        ROW_WE = 1'b1; ROW_IDX = idx; ROW_DATA = data;
        @(posedge CLK); #1;
        ROW_WE = 1'b0;
        if (idx < 5'd20) shadow_m[idx] = data;
    endtask

    task automatic flush_pulse();
        @(posedge CLK); #1;
        FLUSH_REQ = 1'b1;
        @(posedge CLK); #1;
        FLUSH_REQ = 1'b0;
        chk("first_write_next_cycle", {31'b0, AVM_WRITE}, 32'd1);
    endtask

    task automatic check_window(input int b0, input int d0, input int cycles,
                                input int exp_busy, input int exp_done, input string tag);
        repeat (cycles) @(negedge CLK);
        chk({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
        chk({tag, "_done_pulses"}, done_cnt - d0, exp_done);
        chk({tag, "_words_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks the DONE pulse.
    always @(negedge CLK) begin
        logic [43:0] e;
        cyc++;
        if (!RESET) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                chk("done_busy_low", {31'b0, BUSY}, 32'd0);
                chk("done_after_last_word", cyc - last_acc_cyc, 32'd1);
            end
            if (AVM_WRITE) begin
                chk("cs_byte_en", {27'b0, AVM_CS, AVM_BYTE_EN}, {27'b0, 1'b1, 4'b1111});
            end
            if (AVM_WRITE && !AVM_WAITREQUEST) begin
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", AVM_ADDR, AVM_WRITEDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {20'b0, AVM_ADDR}, {20'b0, e[43:32]});
                    chk("wr_data", AVM_WRITEDATA, e[31:0]);
                end
            end
        end
    end

    initial begin
        int b0, d0;
        RESET = 1'b1; ROW_WE = 1'b0; ROW_IDX = 5'd0; ROW_DATA = 20'h0; GAMEOVER = 1'b0;
        VS = 1'b0; FLUSH_REQ = 1'b0; AVM_WAITREQUEST = 1'b0;
        SCORE = 32'h0000_1590; LEVEL = 16'h0003; LINES = 16'h0042; PALETTE = 32'h1234_5678;
        for (int r = 0; r < 20; r++) shadow_m[r] = 20'h00000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_busy_done_write", {29'b0, BUSY, DONE, AVM_WRITE}, 32'd0);
        chk("reset_addr", {20'b0, AVM_ADDR}, 32'd0);
        chk("reset_data", AVM_WRITEDATA, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Full board paint after reset.
        push_header(); push_rows(1'b0);
        b0 = busy_cnt; d0 = done_cnt;
        flush_pulse();
        check_window(b0, d0, 40, 23, 1, "reset_flush");

        // One dirty row; an out-of-range index is ignored.
        row_write(5'd25, 20'hFFFFF);
        row_write(5'd5, 20'hAAAAA);
        SCORE = 32'h0000_2000; LEVEL = 16'h0004; LINES = 16'h0050;
        push_header(); push(12'h007, 32'h000A_AAAA);
        b0 = busy_cnt; d0 = done_cnt;
        flush_pulse();
        check_window(b0, d0, 20, 4, 1, "one_row");

        // GAMEOVER rising marks every row; inputs changed mid-flush are not sampled.
        @(posedge CLK); #1;
        GAMEOVER = 1'b1;
        repeat (2) @(posedge CLK);
        push_header(); push_rows(1'b1);
        b0 = busy_cnt; d0 = done_cnt;
        flush_pulse();
        SCORE = 32'h9999_9999; LEVEL = 16'hFFFF;
        check_window(b0, d0, 40, 23, 1, "gameover");

        // Three-cycle stall on the score word.
        row_write(5'd0, 20'h00003);
        SCORE = 32'h0000_3141;
        push_header(); push(12'h002, 32'h0010_0003);
        b0 = busy_cnt; d0 = done_cnt;
        fork
            begin
                for (int k = 0; k < 50; k++) begin
                    @(posedge CLK); #1;
                    if (AVM_WRITE && AVM_ADDR == 12'h001) break;
                end
                AVM_WAITREQUEST = 1'b1;
                repeat (3) begin
                    @(posedge CLK); #1;
                    chk("stall_addr", {20'b0, AVM_ADDR}, 32'h0000_0001);
                    chk("stall_data", AVM_WRITEDATA, 32'h0000_3141);
                end
                AVM_WAITREQUEST = 1'b0;
            end
        join_none
        flush_pulse();
        check_window(b0, d0, 25, 7, 1, "stall");

        // Requests during a flush collapse into one follow-up flush of the late row 19.
        @(posedge CLK); #1;
        GAMEOVER = 1'b0;
        repeat (2) @(posedge CLK);
        push_header(); push_rows(1'b0);
        push_header(); push(12'h015, 32'h0005_5555);
        b0 = busy_cnt; d0 = done_cnt;
        flush_pulse();
        fork
            begin
                repeat (4) @(posedge CLK);
                #1 FLUSH_REQ = 1'b1;
                @(posedge CLK); #1 FLUSH_REQ = 1'b0;
                repeat (3) @(posedge CLK);
                #1 FLUSH_REQ = 1'b1;
                @(posedge CLK); #1 FLUSH_REQ = 1'b0;
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge CLK); #1;
                    if (AVM_WRITE && AVM_ADDR == 12'h015) break;
                end
                row_write(5'd19, 20'h55555);
            end
        join
        check_window(b0, d0, 40, 27, 2, "pending");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_vga_avl_master.md
Name: tetris_vga_avl_master

Overview:
- Avalon-MM write initiator that pushes Tetris display state into the VGA text/board slave.
- Keeps a local shadow of the 20 board rows with per-row dirty tracking.
- On a flush request, writes the palette, level/lines and score words, then only the dirty board rows, using a standard waitrequest handshake.
- Sits between the game-logic FSM and the VGA slave on the same 50 MHz clock domain.

Parameters:
- NUM_ROWS, 20, number of board rows shadowed; row r maps to word address ROW0_ADDR+r.
- ROW0_ADDR, 12'h002, slave word address of board row 0.
- LVL_ADDR, 12'h000, slave word address of {level, lines}.
- SCORE_ADDR, 12'h001, slave word address of score.
- PAL_ADDR, 12'h800, slave word address of the palette register (bit 11 set).

Ports:
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  synchronous, active-high reset
- ROW_WE  in  1  write one shadow row this cycle
- ROW_IDX  in  5  row index 0..NUM_ROWS-1; values >= NUM_ROWS are ignored
- ROW_DATA  in  20  ten 2-bit cell codes, cell 0 in [1:0]
- GAMEOVER  in  1  game-over flag, sent as bit 20 of every row word
- SCORE  in  32  score word, BCD nibbles, passed through unchanged
- LEVEL  in  16  level value
- LINES  in  16  line count
- PALETTE  in  32  palette register value
- VS  in  1  VGA vertical sync; used only with VSYNC_ALIGN_EN
- FLUSH_REQ  in  1  single-cycle pulse that requests a flush
- BUSY  out  1  flush in progress
- DONE  out  1  one-cycle pulse when a flush completes
- AVM_ADDR  out  12  word address
- AVM_WRITE  out  1  write request
- AVM_CS  out  1  chip select; equals AVM_WRITE
- AVM_BYTE_EN  out  4  constant 4'b1111
- AVM_WRITEDATA  out  32  write data
- AVM_WAITREQUEST  in  1  slave stall; tie 0 for a slave with no stall

Behaviour:
- Reset values:
  - BUSY=0, DONE=0, AVM_WRITE=0, AVM_CS=0, AVM_ADDR=0, AVM_WRITEDATA=0.
  - All shadow rows = 0; dirty mask = all ones, so the first flush paints the whole board.
  - Pending flag = 0.
- Shadow writes:
  - ROW_WE with a valid ROW_IDX writes the row and sets its dirty bit on the next edge.
  - This is accepted in any state, including mid-flush.
- A GAMEOVER change (registered edge detect) sets all dirty bits.
- States: IDLE, (WAIT_VS), PAL, LVL, SCORE, ROWS, FIN.
- IDLE:
  - On FLUSH_REQ or pending=1, latch a snapshot of SCORE, LEVEL, LINES, PALETTE and GAMEOVER.
  - Copy the dirty mask into the work mask and clear the live dirty mask in the same edge. A dirty-set in that same cycle wins and stays set in the live mask.
  - Go to PAL and set BUSY=1.
- Write handshake:
  - In PAL, LVL, SCORE and ROWS, drive AVM_WRITE=1 with address and data held stable while AVM_WAITREQUEST=1.
  - A word is accepted on an edge where AVM_WRITE=1 and AVM_WAITREQUEST=0.
  - With no stalls, the first write appears the cycle after FLUSH_REQ is sampled, and words go out back-to-back, one per cycle.
- Word contents:
  - PAL: PAL_ADDR, snapshot palette.
  - LVL: LVL_ADDR, {LEVEL, LINES}.
  - SCORE: SCORE_ADDR, SCORE.
  - ROWS: write the lowest set bit r of the work mask, data = {11'b0, GAMEOVER_snap, shadow[r]}, address ROW0_ADDR+r. Clear work bit r on acceptance.
  - Row data is read live from the shadow at issue time and held once AVM_WRITE is asserted.
- Clean rows cost zero cycles: the next row comes from a combinational priority encoder. An empty work mask goes from SCORE acceptance directly to FIN.
- FIN: AVM_WRITE=0, DONE=1 for one cycle, BUSY=0 in that same cycle, then IDLE.
- FLUSH_REQ while BUSY sets pending; multiple requests collapse into one. Pending clears when the next flush starts.
- A row written mid-flush after its slot was sent stays dirty for the next flush.
- RESET mid-flush aborts immediately to reset values; an in-flight write is dropped.
- Total words per flush = 3 + popcount(work mask). Address arithmetic is 12-bit; ROW0_ADDR+NUM_ROWS-1 must not exceed 12'h7FF.

Optional Feature:
- Macro: VSYNC_ALIGN_EN.
- Defined: IDLE goes to WAIT_VS instead of PAL. The snapshot is taken on entry to IDLE->WAIT_VS. WAIT_VS leaves to PAL on the first registered falling edge of VS, so board updates land during vertical blanking. BUSY=1 in WAIT_VS.
- Undefined: the WAIT_VS state and VS logic are absent, VS is ignored, and the flush starts the cycle after the request.

Test Plan:
- Reset, FLUSH_REQ, WAITREQUEST=0 -> 23 consecutive writes: 0x800, 0x000, 0x001, then 0x002..0x015 with data 0. DONE pulses the cycle after the 0x015 write. BUSY is high for 23 cycles.
- After a clean flush, ROW_WE idx 5 data 20'hAAAAA, then FLUSH_REQ -> exactly 4 writes, the last at 0x007 with data 32'h000AAAAA.
- Toggle GAMEOVER 0->1, then FLUSH_REQ -> all 20 rows written with bit 20 set, e.g. row data 32'h00100000 for empty rows.
- Hold WAITREQUEST=1 for 3 cycles on the SCORE word -> AVM_ADDR=0x001 and data stay stable across the stall; the flush ends 3 cycles later than without the stall.
- Two FLUSH_REQ pulses during BUSY plus a ROW_WE idx 19 after row 19 was sent -> exactly one extra flush follows, writing only row 19 (4 words).
- With VSYNC_ALIGN_EN: FLUSH_REQ with VS high -> no AVM_WRITE until VS falls; the first write (0x800) follows the registered falling edge.
